// File: rtl/dpram_pkg.sv
// Shared definitions for the dpram stream reader.
// Contents:
//   state_t    - controller states (IDLE, RUN, DRAIN)
//   FIFO_DEPTH - output FIFO depth; also the limit on buffered plus in-flight words
package dpram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/dpram_skid_fifo.sv
// Two-entry output FIFO for the dpram stream reader.
// The head entry drives the output directly, so the data holds steady while the
// consumer stalls.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears entries too)
//   flush        - empties the FIFO; the stored contents are kept but become invalid
//   push, din    - write one entry (caller guarantees space)
//   pop          - remove the head entry (ignored when empty)
//   dout, valid  - head entry and non-empty flag
//   count        - current occupancy
module dpram_skid_fifo
    import dpram_pkg::*;
#(
    parameter int width = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [width-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop_ok;

    assign valid  = (count != 2'd0);
    assign pop_ok = pop && valid;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst reader: streams len words from a dpram read port, starting at base_adr,
// out through a ready/valid interface.
// Optional feature: define DPRAM_READER_LOOP_EN to make a completed burst restart
// at the latched base address with no gap and no done pulse, until abort or rst.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start, base_adr, len  - burst request; base_adr and len are sampled on an accepted start
//   abort                 - ends the current burst and discards buffered and in-flight data
//   en_b, re_b, adr_b     - dpram read port controls and address
//   dat_b                 - dpram read data, one cycle after en_b & re_b
//   m_data, m_valid, m_last, m_ready - output stream
//   busy, done            - burst active; one-cycle completion pulse
module dpram_stream_reader
    import dpram_pkg::*;
#(
    parameter int adr_width = 13,
    parameter int dat_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [adr_width-1:0] base_adr,
    input  logic [adr_width:0]   len,
    input  logic                 abort,
    output logic                 en_b,
    output logic                 re_b,
    output logic [adr_width-1:0] adr_b,
    input  logic [dat_width-1:0] dat_b,
    output logic [dat_width-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done
);

`ifdef DPRAM_READER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t               state, state_nxt;
    logic [adr_width-1:0] adr_q, base_q;
    logic [adr_width:0]   len_q, rem_q;
    logic                 inflight_q, inflight_last_q;
    logic                 done_q;

    logic [1:0]           fifo_count;
    logic [dat_width:0]   fifo_dout;
    logic                 fifo_valid;
    logic [2:0]           fill;
    logic                 abort_act, xfer, final_xfer;
    logic                 accept, zero_start, issue, issue_last;

    assign abort_act  = abort && (state != IDLE);
    assign xfer       = fifo_valid && m_ready;
    assign final_xfer = xfer && fifo_dout[dat_width];
    assign accept     = (state == IDLE) && start && !abort && (len != '0);
    assign zero_start = (state == IDLE) && start && !abort && (len == '0);

    // Space is counted after this cycle's pop, so the head word leaving in the
    // same cycle frees its slot immediately; that is what allows one word per
    // cycle with only two entries and a one-cycle read latency.
    assign fill       = {1'b0, fifo_count} - {2'b0, xfer} + {2'b0, inflight_q};
    assign issue      = (state == RUN) && !abort_act && (fill < 3'(FIFO_DEPTH));
    assign issue_last = (rem_q == {{adr_width{1'b0}}, 1'b1});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN: begin
                if (abort_act)                              state_nxt = IDLE;
                else if (issue && issue_last && !LOOP_EN)   state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort_act || final_xfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q           <= '0;
            base_q          <= '0;
            len_q           <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= zero_start || ((state == DRAIN) && !abort_act && final_xfer);
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;
            if (accept) begin
                base_q <= base_adr;
                len_q  <= len;
                adr_q  <= base_adr;
                rem_q  <= len;
            end else if (issue) begin
                if (issue_last && LOOP_EN) begin
                    adr_q <= base_q;
                    rem_q <= len_q;
                end else begin
                    adr_q <= adr_q + 1'b1;
                    rem_q <= rem_q - 1'b1;
                end
            end
        end
    end

    // The last flag travels with each read so m_last lines up with its word.
    dpram_skid_fifo #(.width(dat_width + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort_act),
        .push  (inflight_q && !abort_act),
        .din   ({inflight_last_q, dat_b}),
        .pop   (xfer),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign en_b    = issue;
    assign re_b    = issue;
    assign adr_b   = adr_q;
    assign m_data  = fifo_dout[dat_width-1:0];
    assign m_valid = fifo_valid;
    assign m_last  = fifo_valid && fifo_dout[dat_width];
    assign busy    = (state != IDLE);
    assign done    = done_q;

endmodule
